// File: rtl/sd_wb_sector_slave.sv
// Wishbone classic single-beat slave backed by a word RAM holding whole 512-byte sectors.
// Serves the SD manager's DMA sector bursts with programmable wait states and error response.
module sd_wb_sector_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk_50,
  input  logic        reset_n,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  input  logic [3:0]  wbs_sel_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [2:0]  wbs_cti_i,
  input  logic [1:0]  wbs_bte_i,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN  = 32'(DEPTH_WORDS * 4);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_HOLD} state_t;

  state_t             state, state_next;
  logic [3:0]         wait_cnt;
  logic [IDX_W-1:0]   idx_q;
  logic [31:0]        dat_q;
  logic [3:0]         sel_q;
  logic               we_q;
  logic               err_q;

  logic [31:0]        mem [DEPTH_WORDS];

  logic [32:0]        off;
  logic               dec_err;
  logic [IDX_W-1:0]   dec_idx;

  logic               go_resp;
  logic               cur_err;
  logic               cur_we;
  logic [IDX_W-1:0]   cur_idx;
  logic               ack_d;
  logic               err_d;
  logic               rd_load;
  logic               commit_wr;
  logic               commit_rd;

  logic               unused_bus_hints;
  assign unused_bus_hints = ^{wbs_cti_i, wbs_bte_i};

  // 33-bit subtract: bit 32 is the borrow, flagging addresses below the window
  assign off     = {1'b0, wbs_adr_i} - {1'b0, BASE_ADDR};
  assign dec_err = off[32] | (off[31:0] >= SPAN) | (wbs_adr_i[1:0] != 2'b00);
  assign dec_idx = off[IDX_W+1:2];

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: if (wbs_cyc_i && wbs_stb_i)
                state_next = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
      S_WAIT: if (!wbs_cyc_i)         state_next = S_IDLE;
              else if (wait_cnt <= 4'd1) state_next = S_RESP;
      S_RESP: state_next = S_HOLD;
      S_HOLD: if (!wbs_stb_i || !wbs_cyc_i) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Responses are registered on entry to RESP; with no wait states the entry
  // happens at the capture edge, so the live decode is used instead of the latch.
  always_comb begin
    go_resp   = (state_next == S_RESP);
    cur_err   = (state == S_IDLE) ? dec_err   : err_q;
    cur_we    = (state == S_IDLE) ? wbs_we_i  : we_q;
    cur_idx   = (state == S_IDLE) ? dec_idx   : idx_q;
    ack_d     = go_resp && !cur_err;
    err_d     = go_resp && cur_err;
    rd_load   = ack_d && !cur_we;
    commit_wr = (state == S_RESP) && !err_q && we_q;
    commit_rd = (state == S_RESP) && !err_q && !we_q;
  end

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
      idx_q    <= '0;
      dat_q    <= '0;
      sel_q    <= '0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (state == S_IDLE && wbs_cyc_i && wbs_stb_i) begin
        wait_cnt <= 4'(WAIT_STATES);
        idx_q    <= dec_idx;
        dat_q    <= wbs_dat_i;
        sel_q    <= wbs_sel_i;
        we_q     <= wbs_we_i;
        err_q    <= dec_err;
      end else if (state == S_WAIT) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
    end
  end

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      wbs_ack_o <= 1'b0;
      wbs_err_o <= 1'b0;
      wbs_dat_o <= '0;
      rd_count  <= '0;
      wr_count  <= '0;
    end else begin
      wbs_ack_o <= ack_d;
      wbs_err_o <= err_d;
      if (rd_load)   wbs_dat_o <= mem[cur_idx];
      if (commit_rd) rd_count  <= rd_count + 16'd1;
      if (commit_wr) wr_count  <= wr_count + 16'd1;
    end
  end

  always_ff @(posedge clk_50) begin
    if (commit_wr) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (sel_q[b]) mem[idx_q][8*b +: 8] <= dat_q[8*b +: 8];
      end
    end
  end

endmodule

// File: doc/sd_wb_sector_slave.md
Name: sd_wb_sector_slave

Overview:
- Wishbone classic single-beat slave: the responder end for the SD manager's Wishbone DMA master.
- Backs a byte-addressed window with an internal word RAM that holds whole 512-byte sectors.
- Serves the master's read-sector (fill BRAM) and write-sector (drain BRAM) bursts of 128 single-word cycles, with programmable wait states and error response.
- Used as the system-RAM stand-in in integration and as a small on-chip sector store.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of window start; must be 4-aligned.
- DEPTH_WORDS, 256, RAM depth in 32-bit words; 256 = 2 sectors; power of two.
- WAIT_STATES, 2, idle cycles inserted between request capture and ack; 0..15.

Ports:
- clk_50  in  1  bus clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_dat_o  out  32  read data; valid in the ack cycle.
- wbs_sel_i  in  4  byte enables; bit n maps to dat[8n+7:8n].
- wbs_cyc_i  in  1  cycle valid.
- wbs_stb_i  in  1  strobe.
- wbs_we_i  in  1  1 = write.
- wbs_cti_i  in  3  cycle type; ignored, every cycle is treated as classic.
- wbs_bte_i  in  2  burst type; ignored.
- wbs_ack_o  out  1  normal termination, one-cycle pulse.
- wbs_err_o  out  1  error termination, one-cycle pulse.
- rd_count  out  16  count of acked reads; wraps.
- wr_count  out  16  count of acked writes; wraps.

Behaviour:
- Reset (async assert, sync use on the next edge): state=IDLE; wbs_ack_o=0, wbs_err_o=0, wbs_dat_o=0, rd_count=0, wr_count=0. RAM contents are not cleared.
- States: IDLE, WAIT, RESP, HOLD.
- IDLE: if cyc&stb, latch adr/dat/sel/we and evaluate decode.
  - Load wait counter with WAIT_STATES.
  - Go to WAIT, or to RESP if WAIT_STATES==0.
- Decode error condition: any of:
  - adr < BASE_ADDR
  - adr >= BASE_ADDR + DEPTH_WORDS*4
  - adr[1:0] != 0
- Word index = (adr - BASE_ADDR) >> 2, truncated to log2(DEPTH_WORDS) bits.
- WAIT: decrement counter; when it reaches 1, go to RESP.
  - If cyc falls, abort to IDLE: no ack, no write, no count.
- RESP, one cycle:
  - Decode error: drive err_o=1, ack_o=0; no RAM write.
  - Otherwise drive ack_o=1.
    - Write: RAM bytes updated per sel, applied at this edge; wr_count+1.
    - Read: dat_o=RAM[index], with sel ignored and the full word returned; rd_count+1.
  - Go to HOLD.
- Latency: ack/err asserted WAIT_STATES+1 cycles after the cycle in which cyc&stb is first sampled.
- HOLD: ack_o=0, err_o=0.
  - Return to IDLE once stb==0 or cyc==0 is sampled.
  - This prevents a lingering strobe from being re-served: each transfer requires a strobe low gap.
  - The DMA master drops stb the cycle after ack, so HOLD lasts 1 cycle.
- dat_o holds its last read value outside RESP. Write cycles do not change dat_o.
- Read-after-write to the same word in consecutive transfers returns the new data.
- cyc dropping in RESP: the response still completes (single-cycle, already committed).
- reset_n asserted mid-transfer: ack/err drop immediately; any write not yet at its RESP edge is lost.

Test Plan:
- Reset, WAIT_STATES=2; write adr=0x10, dat=0xDEADBEEF, sel=4'hF, then read adr=0x10 -> ack 3 cycles after stb in each transfer, read dat_o=0xDEADBEEF, wr_count=1, rd_count=1.
- Byte enables: RAM[0]=0x11223344; write adr=0x0, dat=0xAABBCCDD, sel=4'b0101 -> a read returns 0x11BB33DD.
- Out of range and misaligned: with DEPTH_WORDS=256, BASE=0, access adr=0x400 and adr=0x2 -> err_o one-cycle pulse each, no ack, counters unchanged, RAM unchanged.
- DMA master full sector, write then read:
  - Connect master, ext_write_addr=1: 128 acks, wr_count=128, words 128..255 equal the BRAM pattern.
  - Then ext_read_addr=1: master BRAM receives an identical pattern, rd_count=128.
- Abort: cyc deasserted during WAIT on a write to 0x20 -> no ack/err, RAM[8] unchanged, wr_count unchanged; next transfer served normally.
- Held strobe: keep cyc&stb high for 10 cycles with WAIT_STATES=0 -> exactly one ack pulse, counter +1; ack again only after stb low for ≥1 cycle.
